// File: rtl/core_pkg.sv
// Shared definitions for the five-stage MIPS core pipeline.
//
// Contents:
//   PC_RST_DEFAULT   PC presented by reset bubbles
//   NLANE_DEFAULT    default number of data lanes carried between stages
//   stage_state_t    occupancy of a pipe_stage_reg (EMPTY / ONE / TWO beats held)
//   LANE_*           lane index for each data-lane role
//   lane_lo()        bit offset of a lane inside a packed lane bus
package core_pkg;

    localparam logic [31:0] PC_RST_DEFAULT = 32'h00003000;
    localparam int          NLANE_DEFAULT  = 6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // Every stage packs its lanes in this order, so a lane produced in
    // one stage is found at the same offset in all later stages.
    localparam int LANE_ALU   = 0;
    localparam int LANE_DM    = 1;
    localparam int LANE_EXT   = 2;
    localparam int LANE_CMP   = 3;
    localparam int LANE_MD    = 4;
    localparam int LANE_SPARE = 5;

    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one {pc, a3, data} holding register of a pipeline stage.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   load                capture d_pc / d_a3 / d_data
//   clear               turn the slot into a bubble carrying clear_pc
//   clear_pc            PC kept by the bubble
//   d_pc, d_a3, d_data  incoming beat
//   q_pc, q_a3, q_data  held beat
//
// Priority is reset, then clear, then load. A bubble always holds a3=0 and
// data=0 so it can never write the register file or forward data.
module pipe_slot #(
    parameter int          WD     = 192,
    parameter int          AW     = 5,
    parameter logic [31:0] RST_PC = 32'h00003000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  logic [31:0]   clear_pc,
    input  logic [31:0]   d_pc,
    input  logic [AW-1:0] d_a3,
    input  logic [WD-1:0] d_data,
    output logic [31:0]   q_pc,
    output logic [AW-1:0] q_a3,
    output logic [WD-1:0] q_data
);

    // Holding register; clear wins over load so a flush cannot be
    // overridden by a beat arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_pc   <= RST_PC;
            q_a3   <= '0;
            q_data <= '0;
        end else if (clear) begin
            q_pc   <= clear_pc;
            q_a3   <= '0;
            q_data <= '0;
        end else if (load) begin
            q_pc   <= d_pc;
            q_a3   <= d_a3;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid bit,
// ready/valid handshake, 2-entry skid buffer and flush-to-bubble.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   in_valid       upstream beat valid
//   in_ready       stage can accept a beat (registered)
//   in_pc          upstream PC
//   in_a3          upstream destination register
//   in_data        upstream lanes, lane k at [k*DW +: DW]
//   flush          discard all held and incoming beats
//   flush_pc       PC carried by the flush bubble
//   out_valid      downstream beat valid
//   out_ready      downstream accepts the beat
//   out_pc         PC of the presented beat (bubble PC when out_valid=0)
//   out_a3         destination register, 0 for bubbles
//   out_data       lanes, all 0 for bubbles
//
// MAIN drives the outputs directly; SKID holds the one extra beat accepted
// while the output is stalled. Every output comes straight from a flop.
module pipe_stage_reg
    import core_pkg::*;
#(
    parameter int          NLANE  = NLANE_DEFAULT,
    parameter int          DW     = 32,
    parameter int          AW     = 5,
    parameter logic [31:0] PC_RST = PC_RST_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_pc,
    input  logic [AW-1:0]       in_a3,
    input  logic [NLANE*DW-1:0] in_data,
    input  logic                flush,
    input  logic [31:0]         flush_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_pc,
    output logic [AW-1:0]       out_a3,
    output logic [NLANE*DW-1:0] out_data
);

    localparam int WD = NLANE * DW;

    stage_state_t  state;
    stage_state_t  next_state;

    logic          accept;
    logic          drain;

    logic          main_load;
    logic          main_clear;
    logic          main_from_skid;
    logic [31:0]   main_clear_pc;
    logic [31:0]   main_d_pc;
    logic [AW-1:0] main_d_a3;
    logic [WD-1:0] main_d_data;

    logic          skid_load;
    logic          skid_clear;
    logic [31:0]   skid_pc;
    logic [AW-1:0] skid_a3;
    logic [WD-1:0] skid_data;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // State register plus the registered handshake flags. out_valid and
    // in_ready are decoded from next_state so they stay in step with state
    // while still being plain flops on the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= next_state;
            out_valid <= (next_state != EMPTY);
            in_ready  <= (next_state != TWO);
        end
    end

    // Occupancy transitions. In TWO in_ready is low, so accept cannot fire
    // there; flush empties the stage whatever else happens.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) next_state = ONE;
                ONE: begin
                    if (accept && !drain) next_state = TWO;
                    else if (drain && !accept) next_state = EMPTY;
                end
                TWO: if (drain) next_state = ONE;
                default: next_state = EMPTY;
            endcase
        end
    end

    // Slot controls. A drain to EMPTY clears MAIN to a bubble that keeps
    // the drained PC; a flush clears both slots and installs flush_pc.
    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        main_clear_pc  = out_pc;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            main_clear    = 1'b1;
            main_clear_pc = flush_pc;
            skid_clear    = 1'b1;
        end else begin
            case (state)
                EMPTY: if (accept) main_load = 1'b1;
                ONE: begin
                    if (drain && accept) main_load = 1'b1;
                    else if (drain) main_clear = 1'b1;
                    else if (accept) skid_load = 1'b1;
                end
                TWO: begin
                    if (drain) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: main_clear = 1'b1;
            endcase
        end
    end

    // MAIN is fed either by the upstream beat or by the beat waiting in SKID.
    always_comb begin
        main_d_pc   = main_from_skid ? skid_pc   : in_pc;
        main_d_a3   = main_from_skid ? skid_a3   : in_a3;
        main_d_data = main_from_skid ? skid_data : in_data;
    end

    pipe_slot #(.WD(WD), .AW(AW), .RST_PC(PC_RST)) u_main (
        .clk      (clk),
        .reset    (reset),
        .load     (main_load),
        .clear    (main_clear),
        .clear_pc (main_clear_pc),
        .d_pc     (main_d_pc),
        .d_a3     (main_d_a3),
        .d_data   (main_d_data),
        .q_pc     (out_pc),
        .q_a3     (out_a3),
        .q_data   (out_data)
    );

    pipe_slot #(.WD(WD), .AW(AW), .RST_PC(PC_RST)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .clear    (skid_clear),
        .clear_pc (flush_pc),
        .d_pc     (in_pc),
        .d_a3     (in_a3),
        .d_data   (in_data),
        .q_pc     (skid_pc),
        .q_a3     (skid_a3),
        .q_data   (skid_data)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed vectors with literal expectations
// plus a queue-based model compared against the outputs on every cycle.
module tb_pipe_stage_reg;

    localparam int          NLANE  = 6;
    localparam int          DW     = 32;
    localparam int          AW     = 5;
    localparam int          WD     = NLANE * DW;
    localparam logic [31:0] PC_RST = 32'h00003000;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [AW-1:0] in_a3;
    logic [WD-1:0] in_data;
    logic          flush;
    logic [31:0]   flush_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [AW-1:0] out_a3;
    logic [WD-1:0] out_data;

    int total;
    int bad;

    pipe_stage_reg #(.NLANE(NLANE), .DW(DW), .AW(AW), .PC_RST(PC_RST)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_a3     (in_a3),
        .in_data   (in_data),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_a3    (out_a3),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane contents derived from the PC so directed checks can predict data.
    function automatic logic [WD-1:0] mkdata(input logic [31:0] pc);
        logic [WD-1:0] d;
        d = '0;
        for (int k = 0; k < NLANE; k++) d[k*DW +: DW] = pc + 32'h00010000 * k + 32'h5;
        return d;
    endfunction

    // Behavioural model: a FIFO of at most two beats in arrival order, the
    // PC a bubble presents, and the ready flag seen by the producer.
    typedef struct {
        logic [31:0]   pc;
        logic [AW-1:0] a3;
        logic [WD-1:0] data;
    } beat_t;

    beat_t       mq[$];
    logic [31:0] m_pc;
    logic        m_ready;
    logic        m_live;

    initial begin
        m_live  = 1'b0;
        m_ready = 1'b1;
        m_pc    = PC_RST;
    end

    always @(posedge clk) begin
        logic  acc;
        logic  drn;
        beat_t b;
        acc = in_valid && m_ready;
        drn = (mq.size() > 0) && out_ready;
        if (reset) begin
            mq.delete();
            m_pc    = PC_RST;
            m_ready = 1'b1;
            m_live  = 1'b1;
        end else if (flush) begin
            mq.delete();
            m_pc    = flush_pc;
            m_ready = 1'b1;
        end else begin
            if (drn) begin
                b    = mq.pop_front();
                m_pc = b.pc;
            end
            if (acc) begin
                b.pc   = in_pc;
                b.a3   = in_a3;
                b.data = in_data;
                mq.push_back(b);
            end
            m_ready = (mq.size() < 2);
        end
    end

    // Per-cycle comparison against the model, plus the bubble invariant.
    always @(negedge clk) begin
        logic          e_valid;
        logic [31:0]   e_pc;
        logic [AW-1:0] e_a3;
        logic [WD-1:0] e_data;
        if (m_live) begin
            e_valid = (mq.size() > 0);
            e_pc    = e_valid ? mq[0].pc : m_pc;
            e_a3    = e_valid ? mq[0].a3 : '0;
            e_data  = e_valid ? mq[0].data : '0;
            total++;
            if (out_valid !== e_valid || out_pc !== e_pc || out_a3 !== e_a3 || out_data !== e_data || in_ready !== m_ready) begin
                bad++;
                $display("[TB] FAIL model t=%0t: got v=%b pc=%h a3=%0d rdy=%b, want v=%b pc=%h a3=%0d rdy=%b (data match=%b)",
                         $time, out_valid, out_pc, out_a3, in_ready, e_valid, e_pc, e_a3, m_ready, out_data === e_data);
            end
            if (out_valid === 1'b0) begin
                total++;
                if (out_a3 !== '0 || out_data !== '0) begin
                    bad++;
                    $display("[TB] FAIL bubble t=%0t: got a3=%0d data_nonzero=%b, want a3=0 data=0",
                             $time, out_a3, out_data !== '0);
                end
            end
        end
    end

    // Drive one cycle of inputs, then wait past the next rising edge.
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv, input logic ordy,
                                 input logic [31:0] pc, input logic [AW-1:0] a3,
                                 input logic [WD-1:0] data, input logic [31:0] fpc);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_pc     = pc;
        in_a3     = a3;
        in_data   = data;
        flush_pc  = fpc;
        @(posedge clk);
        #2;
    endtask

    // Literal expectation; a valid beat must carry mkdata(pc) in its lanes.
    task automatic checkOutput(input string name, input logic e_valid, input logic [31:0] e_pc,
                               input logic [AW-1:0] e_a3, input logic e_ready);
        logic [WD-1:0] e_data;
        e_data = e_valid ? mkdata(e_pc) : '0;
        total++;
        if (out_valid !== e_valid || out_pc !== e_pc || out_a3 !== e_a3 || in_ready !== e_ready || out_data !== e_data) begin
            bad++;
            $display("[TB] FAIL %s: got v=%b pc=%h a3=%0d rdy=%b, want v=%b pc=%h a3=%0d rdy=%b (data match=%b)",
                     name, out_valid, out_pc, out_a3, in_ready, e_valid, e_pc, e_a3, e_ready, out_data === e_data);
        end
    endtask

    task automatic beat(input logic ordy, input logic [31:0] pc, input logic [AW-1:0] a3);
        applyStimulus(1'b0, 1'b0, 1'b1, ordy, pc, a3, mkdata(pc), 32'h0);
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 1'b0, 1'b0, ordy, 32'h0, '0, '0, 32'h0);
    endtask

    initial begin
        logic [WD-1:0] rdata;
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_a3     = '0;
        in_data   = '0;
        flush_pc  = '0;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, '0, '0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, '0, '0, 32'h0);
        checkOutput("reset", 1'b0, 32'h00003000, 5'd0, 1'b1);

        $display("[TB] streaming");
        beat(1'b1, 32'h00003000, 5'd8);
        checkOutput("stream0", 1'b1, 32'h00003000, 5'd8, 1'b1);
        beat(1'b1, 32'h00003004, 5'd9);
        checkOutput("stream1", 1'b1, 32'h00003004, 5'd9, 1'b1);
        beat(1'b1, 32'h00003008, 5'd10);
        checkOutput("stream2", 1'b1, 32'h00003008, 5'd10, 1'b1);
        idle(1'b1);
        checkOutput("drain_to_empty", 1'b0, 32'h00003008, 5'd0, 1'b1);

        $display("[TB] back-pressure");
        beat(1'b0, 32'h00003000, 5'd8);
        checkOutput("bp_one", 1'b1, 32'h00003000, 5'd8, 1'b1);
        beat(1'b0, 32'h00003004, 5'd9);
        checkOutput("bp_two", 1'b1, 32'h00003000, 5'd8, 1'b0);
        beat(1'b0, 32'h0000300C, 5'd11);
        checkOutput("bp_refused", 1'b1, 32'h00003000, 5'd8, 1'b0);
        beat(1'b1, 32'h0000300C, 5'd11);
        checkOutput("bp_skid_to_main", 1'b1, 32'h00003004, 5'd9, 1'b1);
        beat(1'b1, 32'h0000300C, 5'd11);
        checkOutput("bp_third", 1'b1, 32'h0000300C, 5'd11, 1'b1);
        idle(1'b1);
        checkOutput("bp_empty", 1'b0, 32'h0000300C, 5'd0, 1'b1);

        $display("[TB] flush in TWO");
        beat(1'b0, 32'h00004000, 5'd1);
        beat(1'b0, 32'h00004004, 5'd2);
        checkOutput("fl_two", 1'b1, 32'h00004000, 5'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h00004008, 5'd3, mkdata(32'h00004008), 32'h00004180);
        checkOutput("flush", 1'b0, 32'h00004180, 5'd0, 1'b1);
        idle(1'b1);
        checkOutput("flush_hold", 1'b0, 32'h00004180, 5'd0, 1'b1);

        $display("[TB] reset with flush");
        beat(1'b0, 32'h00005000, 5'd4);
        beat(1'b0, 32'h00005004, 5'd5);
        checkOutput("rf_two", 1'b1, 32'h00005000, 5'd4, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h00005008, 5'd6, mkdata(32'h00005008), 32'h00004180);
        checkOutput("reset_over_flush", 1'b0, 32'h00003000, 5'd0, 1'b1);

        $display("[TB] random traffic");
        for (int n = 0; n < 10000; n++) begin
            for (int k = 0; k < NLANE; k++) rdata[k*DW +: DW] = $urandom;
            applyStimulus(($urandom_range(0, 999) == 0), ($urandom_range(0, 19) == 0),
                          logic'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                          $urandom, AW'($urandom_range(0, 31)), rdata, $urandom);
        end
        idle(1'b1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
